// File: rtl/uart_cmd_sender.sv
// UART command sender: accepts an opcode plus up to three argument bytes and
// serialises the frames for that opcode onto a single idle-high TX line.
module uart_cmd_sender #(
  parameter int GAP_BITS = 0,
  parameter int CNT_W    = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [7:0]       CMD_OP,
  input  logic [7:0]       CMD_ARG0,
  input  logic [7:0]       CMD_ARG1,
  input  logic [7:0]       CMD_ARG2,
  input  logic [CNT_W-1:0] BIT_TICKS,
  input  logic             PAR_EN,
  input  logic             PAR_TYP,
  output logic             TX_OUT,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR
);

  // Bit counter is shared by the data bits (0..7) and the gap bits.
  localparam int BW = $clog2(GAP_BITS + 9);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, GAP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] tick_q, tick_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [1:0]       byte_q, byte_d;
  logic [2:0]       nbytes_q, nbytes_d;
  logic             tx_q, tx_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             frame_end;
  logic             accept;
  logic [7:0]       byte_sel;

  logic [7:0]       op_q, arg0_q, arg1_q, arg2_q;
  logic [CNT_W-1:0] bt_q;
  logic             pen_q, ptyp_q;

  // Number of bytes on the wire for an opcode; zero marks an unsupported one.
  function automatic logic [2:0] op_len(input logic [7:0] op);
    case (op)
      8'hAA:        return 3'd3;
      8'hBB, 8'hDD: return 3'd2;
      8'hCC:        return 3'd4;
      default:      return 3'd0;
    endcase
  endfunction

  assign CMD_READY = (state_q == IDLE) && !err_q;
  assign accept    = CMD_VALID && CMD_READY;
  assign BUSY      = (state_q != IDLE);
  assign TX_OUT    = tx_q;
  assign DONE      = done_q;
  assign ERR       = err_q;

  // Next-state logic: bit timing, frame sequencing and command completion.
  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    nbytes_d  = nbytes_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    frame_end = 1'b0;
    if (state_q == IDLE) begin
      if (accept) begin
        if (op_len(CMD_OP) != 3'd0) begin
          state_d  = START;
          tick_d   = '0;
          bit_d    = '0;
          byte_d   = '0;
          nbytes_d = op_len(CMD_OP);
        end else begin
          err_d = 1'b1;
        end
      end
    end else if (tick_q != bt_q) begin
      tick_d = tick_q + CNT_W'(1);
    end else begin
      tick_d = '0;
      case (state_q)
        START: begin
          state_d = DATA;
          bit_d   = '0;
        end
        DATA: begin
          if (bit_q == BW'(7)) state_d = pen_q ? PARITY : STOP;
          else                 bit_d   = bit_q + BW'(1);
        end
        PARITY: state_d = STOP;
        STOP: begin
          if (GAP_BITS > 0) begin
            state_d = GAP;
            bit_d   = '0;
          end else begin
            frame_end = 1'b1;
          end
        end
        GAP: begin
          if (bit_q == BW'(GAP_BITS - 1)) frame_end = 1'b1;
          else                            bit_d     = bit_q + BW'(1);
        end
        default: state_d = IDLE;
      endcase
      if (frame_end) begin
        if ({1'b0, byte_q} == nbytes_q - 3'd1) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = START;
          byte_d  = byte_q + 2'd1;
        end
      end
    end
  end

  // Line level for the upcoming cycle, so TX_OUT comes straight from a flop.
  always_comb begin
    case (byte_d)
      2'd1:    byte_sel = arg0_q;
      2'd2:    byte_sel = arg1_q;
      2'd3:    byte_sel = arg2_q;
      default: byte_sel = op_q;
    endcase
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = byte_sel[bit_d[2:0]];
      PARITY:  tx_d = (^byte_sel) ^ ptyp_q;
      default: tx_d = 1'b1;
    endcase
  end

  // Control state register with asynchronous reset to an idle, high line.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      tick_q   <= '0;
      bit_q    <= '0;
      byte_q   <= '0;
      nbytes_q <= '0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      nbytes_q <= nbytes_d;
      tx_q     <= tx_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Command payload and line settings, frozen at acceptance.
  always_ff @(posedge CLK) begin
    if (accept) begin
      op_q   <= CMD_OP;
      arg0_q <= CMD_ARG0;
      arg1_q <= CMD_ARG1;
      arg2_q <= CMD_ARG2;
      bt_q   <= BIT_TICKS;
      pen_q  <= PAR_EN;
      ptyp_q <= PAR_TYP;
    end
  end

endmodule

// File: doc/uart_cmd_sender.md
UART_CMD_SENDER -- requirements
Module: uart_cmd_sender

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: CLK and RST.
REQ-002 Parameter GAP_BITS, default 0: number of extra idle (1) bit periods inserted after every stop bit.
REQ-003 Parameter CNT_W, default 8: width of the bit-period counter and of BIT_TICKS.
REQ-004 CLK  input  1  block clock; all state updates on rising edge.
REQ-005 RST  input  1  asynchronous active-high reset.
REQ-006 CMD_VALID  input  1  command request.
REQ-007 CMD_READY  output  1  block can accept a command.
REQ-008 CMD_OP  input  8  opcode byte.
REQ-009 CMD_ARG0 / CMD_ARG1 / CMD_ARG2  input  8 each  argument bytes, sent in this order.
REQ-010 BIT_TICKS  input  CNT_W  bit period minus one, in CLK cycles.
REQ-011 PAR_EN  input  1  parity bit enable.
REQ-012 PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-013 TX_OUT  output  1  serial UART line, idle high; feeds the system RX_IN.
REQ-014 BUSY  output  1  high while a command's frames are being sent.
REQ-015 DONE  output  1  single-cycle pulse at command completion.
REQ-016 ERR  output  1  single-cycle pulse on an unsupported opcode.

Function
REQ-017 A command SHALL be accepted on the rising edge where CMD_VALID and CMD_READY are both 1; CMD_READY SHALL be 1 only in IDLE.
REQ-018 At acceptance, CMD_OP, all three CMD_ARGx, BIT_TICKS, PAR_EN and PAR_TYP SHALL be captured; later input changes SHALL have no effect until the next acceptance.
REQ-019 Byte count per opcode SHALL be: 0xAA -> 3 (op, ARG0, ARG1); 0xBB -> 2 (op, ARG0); 0xCC -> 4 (op, ARG0, ARG1, ARG2); 0xDD -> 2 (op, ARG0).
REQ-020 Any other opcode SHALL produce no frame: ERR pulses the cycle after acceptance, BUSY stays 0, CMD_READY is 0 for exactly that one cycle and 1 afterwards.
REQ-021 Each byte frame SHALL be: start bit 0; 8 data bits LSB first; parity bit if PAR_EN; stop bit 1; then GAP_BITS idle bits at 1.
REQ-022 Parity bit SHALL equal XOR of the 8 data bits when PAR_TYP = 0, and its inverse when PAR_TYP = 1.
REQ-023 Every bit, including gap bits, SHALL last exactly BIT_TICKS+1 CLK cycles; BIT_TICKS = 0 gives 1-cycle bits.
REQ-024 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP, GAP; PARITY is skipped when PAR_EN = 0 and GAP when GAP_BITS = 0.
REQ-025 After STOP or GAP, the FSM SHALL go to START if bytes remain, else to IDLE; there SHALL be no dead cycle between frames.
REQ-026 TX_OUT SHALL go low in the first cycle after acceptance; BUSY SHALL be 1 from that cycle until the last bit period ends.
REQ-027 DONE SHALL pulse in the first cycle after the last bit period; in that same cycle BUSY = 0 and CMD_READY = 1.
REQ-028 A command of N bytes SHALL take exactly N*(10+PAR_EN+GAP_BITS)*(BIT_TICKS+1) cycles from acceptance to DONE.
REQ-029 TX_OUT SHALL be register-driven and glitch-free; it SHALL be 1 in IDLE.
REQ-030 When CMD_VALID is held high, the next command SHALL be accepted in the DONE cycle, and its start bit SHALL begin the cycle after.

Reset
REQ-031 While RST = 1, outputs SHALL be: TX_OUT = 1, BUSY = 0, DONE = 0, ERR = 0, CMD_READY = 1; the FSM SHALL be in IDLE and all counters SHALL be 0.
REQ-032 Asserting RST mid-frame SHALL force TX_OUT to 1 immediately and abort the command with no DONE; the first command after reset release SHALL be sent correctly.

Verification
REQ-033 Even parity: BIT_TICKS = 3, PAR_EN = 1, PAR_TYP = 0, op 0xAA, ARG0 = 0x05, ARG1 = 0x3C -> 3 frames of 44 cycles each; 0xAA data bits 0,1,0,1,0,1,0,1 with parity 0; DONE pulses 132 cycles after acceptance.
REQ-034 Odd parity: PAR_TYP = 1, op 0xBB, ARG0 = 0x0F, BIT_TICKS = 0 -> parity bit 1 for 0xBB and 1 for 0x0F; 22 cycles to DONE.
REQ-035 ALU command: op 0xCC, PAR_EN = 0, GAP_BITS = 2, BIT_TICKS = 1 -> 4 frames of 24 cycles each; TX_OUT = 1 during gaps; DONE at 96 cycles.
REQ-036 Bad opcode: op 0x12 -> ERR pulses once, TX_OUT stays 1, no DONE, CMD_READY low for exactly 1 cycle.
REQ-037 Back-to-back: CMD_VALID held high with 0xDD then 0xBB -> second command accepted in the DONE cycle; 4 contiguous frames with no extra idle cycle.
REQ-038 Reset mid-frame: RST asserted during a DATA bit of 0xAA -> TX_OUT = 1 asynchronously, no DONE; after release, a 0xDD command completes correctly.
